wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  MEM/WB pipeline register plus write-back logic; sits directly upstream of the register file.
//  Latches one retiring instruction from the MEM stage and selects the result: ALU, aligned/extended load, or link PC+4.
//  Drives the RF write port (RegWrite/RdAddr/RdData) from registered state for one cycle per instruction.
//  The RF commits on negedge inside that cycle.
// PARAMETERS
//  DATA_W    32  datapath width; must be 32
//  ADDR_W    5   register address width
//  LINK_REG  31  destination forced for link write-back
//  CNT_W     32  retire counter width (only with WB_RETIRE_CNT_EN)
// PORTS
//  clk              in   1       clock, all state on posedge
//  rst_n            in   1       asynchronous active-low reset
//  mem_valid        in   1       MEM stage presents an instruction
//  mem_ready        out  1       stage accepts; = !stall
//  mem_reg_write    in   1       instruction writes a register
//  mem_rd_addr      in   ADDR_W  destination register
//  mem_wb_sel       in   2       00 ALU, 01 load, 10 link, 11 reserved (no write)
//  mem_alu_result   in   DATA_W  ALU result; also the load byte address
//  mem_load_data    in   DATA_W  raw 32-bit memory word
//  mem_load_size    in   2       00 word, 01 half, 10 byte, 11 reserved (treated as word)
//  mem_load_uns     in   1       1 = zero-extend, 0 = sign-extend
//  mem_pc_plus4     in   DATA_W  link value
//  stall            in   1       hold stage contents
//  flush            in   1       kill the instruction being captured
//  wb_valid         out  1       stage holds a live instruction
//  rf_reg_write     out  1       to RF RegWrite
//  rf_rd_addr       out  ADDR_W  to RF RdAddr
//  rf_rd_data       out  DATA_W  to RF RdData
//  wb_misalign      out  1       live load was misaligned; write suppressed
//  retire_cnt       out  CNT_W   retired-instruction count (only with WB_RETIRE_CNT_EN)
// BEHAVIOUR
//  - Reset (async, rst_n=0): wb_valid, rf_reg_write, rf_rd_addr, rf_rd_data, wb_misalign and retire_cnt are all 0.
//  - Posedge priority, highest first:
//    - flush: wb_valid <= 0; rf_reg_write <= 0.
//    - stall: hold all state.
//    - otherwise: capture mem_valid and all derived outputs.
//  - Latency: 1 cycle from the accept edge to the RF write-port outputs.
//  - mem_valid=0 with no stall: bubble; wb_valid=0, rf_reg_write=0.
//  - Load extraction, little-endian, offset off = mem_alu_result[1:0]:
//    - byte = word[8*off+7 : 8*off].
//    - half = word[16*off[1]+15 : 16*off[1]].
//    - Extension per mem_load_uns.
//  - Misalignment: half with off[0]=1, or word with off!=0:
//    - wb_misalign=1, rf_reg_write=0, rf_rd_data=0.
//  - Link: rf_rd_addr = LINK_REG regardless of mem_rd_addr; data = mem_pc_plus4.
//  - rf_reg_write = valid & mem_reg_write & (dest != 0) & !misalign & (wb_sel != 11).
//    - Writes to $0 are always suppressed, so RF R0 stays 0.
//  - Stall held for N cycles: rf_reg_write stays asserted.
//    - The RF rewrites the same value on each negedge; this is idempotent and allowed.
//  - Reset asserted mid-write: outputs clear immediately (async); the RF sees RegWrite=0 at its next negedge.
// CONFIGURATION
//  WB_RETIRE_CNT_EN defined:
//    - retire_cnt present.
//    - Increments by 1 on each accept edge where mem_valid=1 and flush=0.
//    - Misaligned instructions are counted.
//    - Wraps 2^CNT_W-1 -> 0; holds during stall.
//  WB_RETIRE_CNT_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  - Reset: rst_n=0 mid-cycle while rf_reg_write=1 -> all outputs 0 immediately; RF reg 5 unchanged.
//  - ALU write-back: rd=5, sel=00, alu=0x1234_5678 -> next cycle RegWrite=1, RdAddr=5, RdData=0x1234_5678.
//  - Signed byte load: word=0x80FF_7F01, alu[1:0]=2, size=10, uns=0 -> RdData=0xFFFF_FFFF.
//    - Same with uns=1 -> 0x0000_00FF.
//  - Half load and misaligned load:
//    - half, off=2, uns=0, word=0x8001_0000 -> RdData=0xFFFF_8001.
//    - half, off=1 -> wb_misalign=1, RegWrite=0.
//  - Link and $0:
//    - sel=10, pc+4=0x0040_0010, rd=7 -> RdAddr=31, RdData=0x0040_0010.
//    - rd=0, ALU result 0xDEAD -> RegWrite=0.
//  - Stall and flush:
//    - stall=1 for 3 cycles -> outputs held, mem_ready=0.
//    - stall=1 and flush=1 together -> wb_valid=0 next cycle.
//    - With WB_RETIRE_CNT_EN: counter 0xFFFF_FFFF wraps to 0.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if: MEM-side capture inputs, pipeline control and RF write-port outputs of wb_stage
interface wb_stage_if #(parameter int DATA_W = 32, parameter int ADDR_W = 5);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_reg_write;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [1:0]        mem_wb_sel;
  logic [DATA_W-1:0] mem_alu_result;
  logic [DATA_W-1:0] mem_load_data;
  logic [1:0]        mem_load_size;
  logic              mem_load_uns;
  logic [DATA_W-1:0] mem_pc_plus4;
  logic              stall;
  logic              flush;
  logic              wb_valid;
  logic              rf_reg_write;
  logic [ADDR_W-1:0] rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data;
  logic              wb_misalign;
  modport master (
    output mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel, mem_alu_result,
           mem_load_data, mem_load_size, mem_load_uns, mem_pc_plus4, stall, flush,
    input  mem_ready, wb_valid, rf_reg_write, rf_rd_addr, rf_rd_data, wb_misalign
  );
  modport slave (
    input  mem_valid, mem_reg_write, mem_rd_addr, mem_wb_sel, mem_alu_result,
           mem_load_data, mem_load_size, mem_load_uns, mem_pc_plus4, stall, flush,
    output mem_ready, wb_valid, rf_reg_write, rf_rd_addr, rf_rd_data, wb_misalign
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB register and write-back select (ALU, aligned/extended load, link PC+4).
// Define WB_RETIRE_CNT_EN to add the retire_cnt output.
module wb_stage #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_REG = 31,
  parameter int CNT_W    = 32
) (
  input  logic clk,
  input  logic rst_n,
  wb_stage_if.slave bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);
  logic [1:0]        off;
  logic [7:0]        byte_v;
  logic [15:0]       half_v;
  logic [DATA_W-1:0] load_v;
  logic              mis;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_data;
  logic              d_we;
  assign bus.mem_ready = ~bus.stall;
  always_comb begin
    off    = bus.mem_alu_result[1:0];
    byte_v = bus.mem_load_data[{off, 3'b000} +: 8];
    half_v = off[1] ? bus.mem_load_data[31:16] : bus.mem_load_data[15:0];
    load_v = bus.mem_load_size == 2'b10 ? {{24{~bus.mem_load_uns & byte_v[7]}}, byte_v} :
             bus.mem_load_size == 2'b01 ? {{16{~bus.mem_load_uns & half_v[15]}}, half_v} :
             bus.mem_load_data;
    // reserved size 11 behaves as a word, so it needs full alignment too
    mis    = bus.mem_valid && bus.mem_wb_sel == 2'b01 &&
             (bus.mem_load_size == 2'b01 ? off[0] : bus.mem_load_size != 2'b10 && off != 2'b00);
    d_addr = bus.mem_wb_sel == 2'b10 ? ADDR_W'(LINK_REG) : bus.mem_rd_addr;
    d_data = mis                      ? '0 :
             bus.mem_wb_sel == 2'b00 ? bus.mem_alu_result :
             bus.mem_wb_sel == 2'b01 ? load_v :
             bus.mem_wb_sel == 2'b10 ? bus.mem_pc_plus4 : '0;
    d_we   = bus.mem_valid && bus.mem_reg_write && d_addr != '0 && !mis && bus.mem_wb_sel != 2'b11;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.wb_valid     <= 1'b0;
      bus.rf_reg_write <= 1'b0;
      bus.rf_rd_addr   <= '0;
      bus.rf_rd_data   <= '0;
      bus.wb_misalign  <= 1'b0;
    end else if (bus.flush) begin
      bus.wb_valid     <= 1'b0;
      bus.rf_reg_write <= 1'b0;
    end else if (!bus.stall) begin
      bus.wb_valid     <= bus.mem_valid;
      bus.rf_reg_write <= d_we;
      bus.rf_rd_addr   <= d_addr;
      bus.rf_rd_data   <= d_data;
      bus.wb_misalign  <= mis;
    end
`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) retire_cnt <= '0;
    else if (!bus.flush && !bus.stall && bus.mem_valid) retire_cnt <= retire_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed vectors for wb_stage with a negedge-commit register file model
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;
  logic [31:0] rf [32];
  wb_stage_if #(.DATA_W(32), .ADDR_W(5)) bus ();
`ifdef WB_RETIRE_CNT_EN
  logic [3:0] retire_cnt;
  wb_stage #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .retire_cnt(retire_cnt));
`else
  wb_stage #(.CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif
  always #5 clk = ~clk;
  always @(negedge clk)
    if (bus.rf_reg_write) rf[bus.rf_rd_addr] <= bus.rf_rd_data;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                     input logic [31:0] alu, input logic [31:0] word, input logic [1:0] size,
                     input logic uns, input logic [31:0] pc4);
    bus.mem_valid = v; bus.mem_reg_write = rw; bus.mem_rd_addr = rd; bus.mem_wb_sel = sel;
    bus.mem_alu_result = alu; bus.mem_load_data = word; bus.mem_load_size = size;
    bus.mem_load_uns = uns; bus.mem_pc_plus4 = pc4; bus.stall = 1'b0; bus.flush = 1'b0;
    tick();
  endtask
  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    bus.mem_valid = 0; bus.mem_reg_write = 0; bus.mem_rd_addr = 0; bus.mem_wb_sel = 0;
    bus.mem_alu_result = 0; bus.mem_load_data = 0; bus.mem_load_size = 0; bus.mem_load_uns = 0;
    bus.mem_pc_plus4 = 0; bus.stall = 0; bus.flush = 0;
    #3;
    chk("rst_valid", {31'b0, bus.wb_valid}, 0);
    chk("rst_we", {31'b0, bus.rf_reg_write}, 0);
    chk("rst_addr", {27'b0, bus.rf_rd_addr}, 0);
    chk("rst_data", bus.rf_rd_data, 0);
    chk("rst_mis", {31'b0, bus.wb_misalign}, 0);
    chk("rst_ready", {31'b0, bus.mem_ready}, 1);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_cnt", {28'b0, retire_cnt}, 0);
`endif
    #9 rst_n = 1'b1;
    put(1, 1, 5, 2'b00, 32'h1234_5678, 0, 0, 0, 0);
    chk("alu_we", {31'b0, bus.rf_reg_write}, 1);
    chk("alu_addr", {27'b0, bus.rf_rd_addr}, 5);
    chk("alu_data", bus.rf_rd_data, 32'h1234_5678);
    chk("alu_valid", {31'b0, bus.wb_valid}, 1);
    put(1, 1, 6, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 2'b10, 0, 0);
    chk("rf5_commit", rf[5], 32'h1234_5678);
    chk("lb_s_data", bus.rf_rd_data, 32'hFFFF_FFFF);
    chk("lb_s_we", {31'b0, bus.rf_reg_write}, 1);
    put(1, 1, 6, 2'b01, 32'h0000_1002, 32'h80FF_7F01, 2'b10, 1, 0);
    chk("lbu_data", bus.rf_rd_data, 32'h0000_00FF);
    put(1, 1, 6, 2'b01, 32'h0000_1003, 32'h80FF_7F01, 2'b10, 1, 0);
    chk("lbu_off3", bus.rf_rd_data, 32'h0000_0080);
    put(1, 1, 6, 2'b01, 32'h0000_1000, 32'h80FF_7F01, 2'b10, 0, 0);
    chk("lb_off0", bus.rf_rd_data, 32'h0000_0001);
    put(1, 1, 8, 2'b01, 32'h0000_2002, 32'h8001_0000, 2'b01, 0, 0);
    chk("lh_data", bus.rf_rd_data, 32'hFFFF_8001);
    chk("lh_mis", {31'b0, bus.wb_misalign}, 0);
    put(1, 1, 8, 2'b01, 32'h0000_2001, 32'h8001_0000, 2'b01, 0, 0);
    chk("lh_mis_flag", {31'b0, bus.wb_misalign}, 1);
    chk("lh_mis_we", {31'b0, bus.rf_reg_write}, 0);
    chk("lh_mis_data", bus.rf_rd_data, 0);
    put(1, 1, 8, 2'b01, 32'h0000_2003, 32'hCAFE_BABE, 2'b00, 0, 0);
    chk("lw_mis_flag", {31'b0, bus.wb_misalign}, 1);
    put(1, 1, 8, 2'b01, 32'h0000_2004, 32'hCAFE_BABE, 2'b11, 0, 0);
    chk("lw_rsv_data", bus.rf_rd_data, 32'hCAFE_BABE);
    chk("lw_rsv_mis", {31'b0, bus.wb_misalign}, 0);
    put(1, 1, 7, 2'b10, 32'h0, 0, 0, 0, 32'h0040_0010);
    chk("link_addr", {27'b0, bus.rf_rd_addr}, 31);
    chk("link_data", bus.rf_rd_data, 32'h0040_0010);
    chk("link_we", {31'b0, bus.rf_reg_write}, 1);
    put(1, 1, 0, 2'b00, 32'h0000_DEAD, 0, 0, 0, 0);
    chk("r0_we", {31'b0, bus.rf_reg_write}, 0);
    chk("r0_valid", {31'b0, bus.wb_valid}, 1);
    put(1, 1, 9, 2'b11, 32'h0000_0077, 0, 0, 0, 0);
    chk("sel11_we", {31'b0, bus.rf_reg_write}, 0);
    put(0, 1, 9, 2'b00, 32'h0000_0077, 0, 0, 0, 0);
    chk("bubble_valid", {31'b0, bus.wb_valid}, 0);
    chk("bubble_we", {31'b0, bus.rf_reg_write}, 0);
    put(1, 1, 9, 2'b00, 32'h0000_0055, 0, 0, 0, 0);
    bus.stall = 1'b1; bus.mem_rd_addr = 10; bus.mem_alu_result = 32'h66;
    #1;
    chk("stall_ready", {31'b0, bus.mem_ready}, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_we", {31'b0, bus.rf_reg_write}, 1);
      chk("stall_addr", {27'b0, bus.rf_rd_addr}, 9);
      chk("stall_data", bus.rf_rd_data, 32'h55);
    end
    bus.flush = 1'b1;
    tick();
    chk("flush_valid", {31'b0, bus.wb_valid}, 0);
    chk("flush_we", {31'b0, bus.rf_reg_write}, 0);
    chk("rf9_commit", rf[9], 32'h55);
    put(1, 1, 5, 2'b00, 32'hAAAA_AAAA, 0, 0, 0, 0);
    chk("pre_rst_we", {31'b0, bus.rf_reg_write}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_we", {31'b0, bus.rf_reg_write}, 0);
    chk("async_data", bus.rf_rd_data, 0);
    chk("async_valid", {31'b0, bus.wb_valid}, 0);
    @(negedge clk);
    #1;
    chk("rf5_kept", rf[5], 32'h1234_5678);
    rst_n = 1'b1;
`ifdef WB_RETIRE_CNT_EN
    chk("cnt_after_rst", {28'b0, retire_cnt}, 0);
    for (int i = 0; i < 15; i++) put(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("cnt_max", {28'b0, retire_cnt}, 15);
    bus.stall = 1'b1;
    tick();
    chk("cnt_stall", {28'b0, retire_cnt}, 15);
    put(1, 1, 0, 2'b00, 0, 0, 0, 0, 0);
    chk("cnt_wrap", {28'b0, retire_cnt}, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
